// File: rtl/partita_pkg.sv
// partita_gen shared types: moves, round/match results, FSM states.
// Imported by round_judge and partita_gen.
package partita_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    M_NONE = 2'b00,
    M_P1   = 2'b01,
    M_P2   = 2'b10,
    M_DRAW = 2'b11
  } manche_t;

  typedef enum logic [1:0] {
    P_NONE = 2'b00,
    P_P1   = 2'b01,
    P_P2   = 2'b10,
    P_TIE  = 2'b11
  } partita_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/round_judge.sv
// round_judge: combinational rock-paper-scissors round referee.
// Ports: a_i/b_i player moves (move_t), res_o round result (manche_t).
module round_judge
  import partita_pkg::*;
(
  input  move_t   a_i,
  input  move_t   b_i,
  output manche_t res_o
);

  logic inv;
  logic draw;
  logic beats;

  assign inv   = (a_i == NONE) || (b_i == NONE);
  assign draw  = !inv && (a_i == b_i);
  assign beats = (a_i == ROCK     && b_i == SCISSORS) ||
                 (a_i == PAPER    && b_i == ROCK)     ||
                 (a_i == SCISSORS && b_i == PAPER);

  always_comb begin
    res_o = M_NONE;
    unique case (1'b1)
      inv:            res_o = M_NONE;
      draw:           res_o = M_DRAW;
      !inv && beats:  res_o = M_P1;
      default:        res_o = M_P2;
    endcase
  end

endmodule

// File: rtl/partita_gen.sv
// partita_gen: rock-paper-scissors match controller (FSM + counters).
// Ports: clk, rst_n (async active-low), INIZIA start strobe,
//   PRIMO/SECONDO moves (config {PRIMO,SECONDO} on INIZIA),
//   MANCHE round result, PARTITA match result (both registered).
// Option: PARTITA_GEN_NOREPEAT_EN forbids a winner repeating the
//   winning move in the next valid round.
module partita_gen
  import partita_pkg::*;
#(
  parameter int MIN_ROUNDS = 4,
  parameter int WIN_MARGIN = 2,
  parameter int CFG_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);

  localparam int CNT_W = $clog2(MIN_ROUNDS + 16);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t   state_q, state_d;
  cnt_t     rounds_q, rounds_d;
  cnt_t     w1_q, w1_d;
  cnt_t     w2_q, w2_d;
  cnt_t     max_q, max_d;
  manche_t  manche_q, manche_d;
  partita_t partita_q, partita_d;

  move_t    mv1, mv2;
  manche_t  res;
  manche_t  eff;
  logic [CFG_W-1:0] cfg;
  cnt_t     diff;

  assign mv1 = move_t'(PRIMO);
  assign mv2 = move_t'(SECONDO);
  assign cfg = {PRIMO, SECONDO};

  round_judge u_judge (
    .a_i   (mv1),
    .b_i   (mv2),
    .res_o (res)
  );

`ifdef PARTITA_GEN_NOREPEAT_EN
  manche_t rep_who_q, rep_who_d;
  move_t   rep_mv_q, rep_mv_d;
  logic    blocked;

  // Valid round where the last winner reuses the winning move.
  assign blocked = (res != M_NONE) &&
    ((rep_who_q == M_P1 && mv1 == rep_mv_q) ||
     (rep_who_q == M_P2 && mv2 == rep_mv_q));
  assign eff = blocked ? M_NONE : res;

  always_comb begin
    rep_who_d = rep_who_q;
    rep_mv_d  = rep_mv_q;
    if (INIZIA) begin
      rep_who_d = M_NONE;
      rep_mv_d  = NONE;
    end else if (state_q == S_PLAY) begin
      case (eff)
        M_DRAW: begin
          rep_who_d = M_NONE;
          rep_mv_d  = NONE;
        end
        M_P1: begin
          rep_who_d = M_P1;
          rep_mv_d  = mv1;
        end
        M_P2: begin
          rep_who_d = M_P2;
          rep_mv_d  = mv2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_who_q <= M_NONE;
      rep_mv_q  <= NONE;
    end else begin
      rep_who_q <= rep_who_d;
      rep_mv_q  <= rep_mv_d;
    end
  end
`else
  assign eff = res;
`endif

  always_comb begin
    state_d   = state_q;
    rounds_d  = rounds_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    max_d     = max_q;
    manche_d  = manche_q;
    partita_d = partita_q;
    diff      = '0;
    if (INIZIA) begin
      max_d     = cnt_t'(MIN_ROUNDS) + cnt_t'(cfg);
      rounds_d  = '0;
      w1_d      = '0;
      w2_d      = '0;
      manche_d  = M_NONE;
      partita_d = P_NONE;
      state_d   = S_PLAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          manche_d  = M_NONE;
          partita_d = P_NONE;
        end
        S_PLAY: begin
          manche_d = eff;
          if (eff != M_NONE) begin
            rounds_d = rounds_q + cnt_t'(1);
            if (eff == M_P1) w1_d = w1_q + cnt_t'(1);
            if (eff == M_P2) w2_d = w2_q + cnt_t'(1);
            diff = (w1_d >= w2_d) ? (w1_d - w2_d) : (w2_d - w1_d);
            if (rounds_d >= cnt_t'(MIN_ROUNDS) &&
                diff >= cnt_t'(WIN_MARGIN)) begin
              partita_d = (w1_d > w2_d) ? P_P1 : P_P2;
              state_d   = S_DONE;
            end else if (rounds_d == max_q) begin
              if (w1_d > w2_d)      partita_d = P_P1;
              else if (w2_d > w1_d) partita_d = P_P2;
              else                  partita_d = P_TIE;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: manche_d = M_NONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rounds_q  <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      max_q     <= '0;
      manche_q  <= M_NONE;
      partita_q <= P_NONE;
    end else begin
      state_q   <= state_d;
      rounds_q  <= rounds_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      max_q     <= max_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
    end
  end

  assign MANCHE  = manche_q;
  assign PARTITA = partita_q;

endmodule

// File: tb/tb_partita_gen.sv
// tb_partita_gen: directed self-checking bench for partita_gen.
// Per-cycle behavioural model compare plus literal expectations.
module tb_partita_gen;

  localparam int MINR = 4;
  localparam int MARG = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ini = 1'b0;
  logic [1:0] p = 2'b00;
  logic [1:0] s = 2'b00;
  logic [1:0] m;
  logic [1:0] pt;

  int tests = 0;
  int fails = 0;
  bit run_cmp = 1'b0;

  // model state: st 0 idle, 1 play, 2 done
  int e_st, e_r, e_w1, e_w2, e_max, e_m, e_p;
  int t_who, t_mv;
  int ma, mb, who, dif;

  partita_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INIZIA  (ini),
    .PRIMO   (p),
    .SECONDO (s),
    .MANCHE  (m),
    .PARTITA (pt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [1:0] act,
                     input int exp);
    tests++;
    if (act !== 2'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      e_st = 0; e_r = 0; e_w1 = 0; e_w2 = 0; e_max = 0;
      e_m = 0; e_p = 0; t_who = 0; t_mv = 0;
    end else if (ini) begin
      e_max = MINR + (int'(p) * 4 + int'(s));
      e_r = 0; e_w1 = 0; e_w2 = 0;
      e_m = 0; e_p = 0; e_st = 1;
      t_who = 0; t_mv = 0;
    end else if (e_st == 1) begin
      ma = int'(p);
      mb = int'(s);
      if (ma == 0 || mb == 0) who = 0;
      else if (ma == mb) who = 3;
      else if (mb == (ma + 1) % 3 + 1) who = 1;
      else who = 2;
`ifdef PARTITA_GEN_NOREPEAT_EN
      if (who != 0 && t_who != 0 &&
          ((t_who == 1 ? ma : mb) == t_mv)) who = 0;
`endif
      e_m = who;
      if (who != 0) begin
        e_r++;
        if (who == 1) e_w1++;
        if (who == 2) e_w2++;
        if (who == 3) begin t_who = 0; t_mv = 0; end
        else begin t_who = who; t_mv = (who == 1) ? ma : mb; end
        dif = e_w1 - e_w2;
        if (dif < 0) dif = -dif;
        if (e_r >= MINR && dif >= MARG) begin
          e_p = (e_w1 > e_w2) ? 1 : 2;
          e_st = 2;
        end else if (e_r == e_max) begin
          e_p = (e_w1 > e_w2) ? 1 : (e_w2 > e_w1) ? 2 : 3;
          e_st = 2;
        end
      end
    end else begin
      e_m = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      chk("model_manche", m, e_m);
      chk("model_partita", pt, e_p);
    end
  end

  task automatic step(input bit i, input logic [1:0] a,
                      input logic [1:0] b);
    @(negedge clk);
    ini = i;
    p = a;
    s = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_manche", m, 0);
    chk("rst_partita", pt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp = 1'b1;

    step(0, 2'd1, 2'd3);
    chk("idle_ignore", m, 0);

    // config 0, P1 margin win on round 4
    step(1, 2'd0, 2'd0);
    step(0, 2'd1, 2'd3); chk("c0_r1_m", m, 1);
    step(0, 2'd2, 2'd1); chk("c0_r2_m", m, 1);
    chk("c0_r2_p", pt, 0);
    step(0, 2'd3, 2'd2); chk("c0_r3_p", pt, 0);
    step(0, 2'd1, 2'd3); chk("c0_r4_m", m, 1);
    chk("c0_r4_p", pt, 1);
    step(0, 2'd1, 2'd3); chk("c0_done_m", m, 0);
    chk("c0_done_p", pt, 1);

    // restart from DONE
    step(1, 2'd0, 2'd0); chk("restart_p", pt, 0);

    // invalid rounds then four P2 wins
    step(0, 2'd0, 2'd2); chk("inv1_m", m, 0);
    step(0, 2'd1, 2'd0); chk("inv2_m", m, 0);
    step(0, 2'd1, 2'd2); chk("p2_r1_m", m, 2);
    step(0, 2'd2, 2'd3);
    step(0, 2'd3, 2'd1); chk("p2_r3_p", pt, 0);
    step(0, 2'd1, 2'd2); chk("p2_r4_p", pt, 2);

    // max-round outcomes: P1, P2, tie
    step(1, 2'd0, 2'd0);
    step(0, 2'd1, 2'd3);
    step(0, 2'd3, 2'd1); chk("t1_r2_m", m, 2);
    step(0, 2'd2, 2'd2); chk("t1_draw_m", m, 3);
    chk("t1_r3_p", pt, 0);
    step(0, 2'd2, 2'd1); chk("t1_max_p", pt, 1);

    step(1, 2'd0, 2'd0);
    step(0, 2'd1, 2'd3);
    step(0, 2'd3, 2'd1);
    step(0, 2'd2, 2'd2);
    step(0, 2'd1, 2'd2); chk("t2_max_p", pt, 2);

    step(1, 2'd0, 2'd0);
    step(0, 2'd1, 2'd3);
    step(0, 2'd3, 2'd1);
    step(0, 2'd2, 2'd2);
    step(0, 2'd3, 2'd3); chk("t3_draw_m", m, 3);
    chk("t3_max_p", pt, 3);

    // extended config: max 6
    step(1, 2'd0, 2'd2);
    step(0, 2'd1, 2'd3);
    step(0, 2'd3, 2'd1);
    step(0, 2'd2, 2'd1); chk("ext_r3_p", pt, 0);
    step(0, 2'd2, 2'd3); chk("ext_r4_p", pt, 0);
    step(0, 2'd3, 2'd2); chk("ext_r5_p", pt, 0);
    step(0, 2'd1, 2'd3); chk("ext_r6_p", pt, 1);

    // async reset mid-PLAY
    step(1, 2'd0, 2'd0);
    step(0, 2'd1, 2'd3); chk("pre_rst_m", m, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_m", m, 0);
    chk("async_rst_p", pt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 2'd1, 2'd3); chk("post_rst_idle", m, 0);

    // repeat-move sequence
    step(1, 2'd0, 2'd0);
    step(0, 2'd2, 2'd1); chk("rep_r1_m", m, 1);
    step(0, 2'd2, 2'd3);
`ifdef PARTITA_GEN_NOREPEAT_EN
    chk("rep_r2_m", m, 0);
`else
    chk("rep_r2_m", m, 2);
`endif
    step(0, 2'd1, 2'd3); chk("rep_r3_m", m, 1);

    repeat (2) @(negedge clk);
    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
